peripheral_tx: RTL and testbench

PERIPHERAL_TX -- requirements
Module: peripheral_tx

---
 rtl/peripheral_tx_pkg.sv | 18 +
 rtl/peripheral_tx_fifo.sv | 50 +++++
 rtl/peripheral_tx.sv | 162 ++++++++++++++++
 tb/tb_peripheral_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_tx_pkg.sv
// Shared types and constants for the peripheral serial transmitter.
// Holds the serializer state enum, frame bit counts and default bit timing.
package peripheral_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS_BASE      = 10;
    localparam int FRAME_BITS_PARITY    = 11;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/peripheral_tx_fifo.sv
// periph_fifo: word FIFO feeding the serializer, pointer MSB full/empty scheme.
// Ports: clk, rst (async high), push/din in, pop in, dout (head word), full, empty.
module periph_fifo
    import peripheral_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign w_rd  = pop && !empty;
    assign w_wr  = push && (!full || w_rd);
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign dout  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/peripheral_tx.sv
// peripheral_tx: buffers 16-bit words and sends each as two UART-style bytes, low first.
// Ports: clk, rst (async high), wr_en/wr_data in; full, busy, overflow, tx out.
// Optional macro PERIPH_TX_PARITY_EN adds an even parity bit after the data bits.
module peripheral_tx
    import peripheral_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);
    localparam logic [7:0] CNT_LOAD = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t   r_state;
    tx_state_t   w_next;
    logic [7:0]  r_cnt;
    logic [2:0]  r_bit;
    logic        r_byte_sel;
    logic [15:0] r_shift;
    logic        r_ovf;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_bit_done;
    logic [15:0] w_dout;
`ifdef PERIPH_TX_PARITY_EN
    logic        r_par;
`endif

    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_bit_done = (r_cnt == 8'd0);
    assign full       = w_full;
    assign overflow   = r_ovf;

    periph_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (!w_empty) w_next = S_START;
            S_START:  if (w_bit_done) w_next = S_DATA;
            S_DATA: begin
                if (w_bit_done && r_bit == LAST_BIT) begin
`ifdef PERIPH_TX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (w_bit_done) w_next = S_STOP;
            S_STOP:   if (w_bit_done) w_next = r_byte_sel ? S_IDLE : S_START;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (r_state != S_IDLE) || !w_empty;
        unique case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
`ifdef PERIPH_TX_PARITY_EN
            S_PARITY: tx = r_par;
`else
            S_PARITY: tx = 1'b1;
`endif
            default:  tx = 1'b1;
        endcase
    end

    // Counter is reloaded on every bit boundary; the shift register moves
    // one place per data bit so the high byte is in place after the low byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_byte_sel <= 1'b0;
            r_shift    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (wr_en && w_full && !w_pop) r_ovf <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_dout;
                        r_byte_sel <= 1'b0;
                        r_cnt      <= CNT_LOAD;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_cnt <= CNT_LOAD;
                        r_bit <= '0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt   <= CNT_LOAD;
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {1'b0, r_shift[15:1]};
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) r_cnt <= CNT_LOAD;
                    else            r_cnt <= r_cnt - 8'd1;
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_cnt      <= r_byte_sel ? 8'd0 : CNT_LOAD;
                        r_byte_sel <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

`ifdef PERIPH_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (r_state == S_START) begin
            r_par <= 1'b0;
        end else if (r_state == S_DATA && w_bit_done) begin
            r_par <= r_par ^ r_shift[0];
        end
    end
`endif

endmodule

// File: tb/tb_peripheral_tx.sv
// Self-checking bench for peripheral_tx: table-driven writes plus a
// serial-line receiver feeding a byte scoreboard.
module tb_peripheral_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef PERIPH_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WORD_CYC = 2 * FB * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        busy;
    logic        overflow;
    logic        tx;

    int n_pass  = 0;
    int n_total = 0;
    int rx_cnt  = 0;
    logic [7:0] exp_q[$];
    int         g_q[$];
    logic       p_q[$];

    peripheral_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic wr(input logic [15:0] d, input bit acc);
        wr_data = d;
        wr_en   = 1'b1;
        if (acc) begin
            exp_q.push_back(d[7:0]);
            exp_q.push_back(d[15:8]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Serial receiver: every cycle of every bit must hold the same level.
    initial begin : mon
        int         mcyc;
        int         s;
        int         last_end;
        bit         abort;
        bit         glitch;
        logic [FB-1:0] bits;
        logic [7:0] b;
        mcyc     = 0;
        last_end = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst === 1'b0 && tx === 1'b0) begin
                s      = mcyc;
                abort  = 1'b0;
                glitch = 1'b0;
                bits   = '0;
                for (int i = 0; i < FB; i++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(i == 0 && c == 0)) begin
                            @(negedge clk);
                            mcyc++;
                        end
                        if (rst !== 1'b0) abort = 1'b1;
                        else if (c == 0) bits[i] = tx;
                        else if (tx !== bits[i]) glitch = 1'b1;
                    end
                end
                if (!abort) begin
                    g_q.push_back(s - last_end - 1);
                    last_end = mcyc;
                    rx_cnt++;
                    b = bits[8:1];
                    chk("rx_frame", {30'd0, glitch, bits[FB-1]}, 32'd1);
`ifdef PERIPH_TX_PARITY_EN
                    p_q.push_back(bits[9]);
                    chk("rx_parity", 32'(bits[9]), 32'(^b));
`endif
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL rx_unexpected: got %02h want none", b);
                    end else begin
                        chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    typedef struct {
        logic [15:0] data;
        int          gap;
        bit          acc;
        bit          e_full;
        bit          e_ovf;
    } vec_t;

    initial begin : main
        vec_t        vecs[6];
        logic [15:0] cw[4];
        int          cnt;
        int          rx0;
        int          lows;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single word: latency, frame content, busy length
        wr(16'hA55A, 1'b1);
        chk("a_tx_hold", 32'(tx), 32'd1);
        chk("a_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("a_start_fall", 32'(tx), 32'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
        chk("a_busy_len", 32'(cnt), 32'(WORD_CYC));
        drain("a");

        // table: fill behind a word in flight, fifth write overflows
        vecs[0] = '{16'h00AA, 2, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'h0001, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0002, 0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h0003, 0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h0004, 0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0005, 3, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].data, vecs[i].acc);
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            repeat (vecs[i].gap) @(negedge clk);
        end
        drain("b");
        chk("b_ovf_sticky", 32'(overflow), 32'd1);
        pulse_reset();
        chk("b_ovf_cleared", 32'(overflow), 32'd0);

        // write to a full FIFO on the exact pop cycle
        cw[0] = 16'h2222;
        cw[1] = 16'h3333;
        cw[2] = 16'h4444;
        cw[3] = 16'h5555;
        wr(16'h1111, 1'b1);
        for (int j = 0; j < 4; j++) wr(cw[j], 1'b1);
        chk("c_full", 32'(full), 32'd1);
        repeat (WORD_CYC + 1 - 4) @(negedge clk);
        wr(16'h6666, 1'b1);
        chk("c_full_after", 32'(full), 32'd1);
        chk("c_ovf", 32'(overflow), 32'd0);
        drain("c");
        chk("c_ovf_end", 32'(overflow), 32'd0);

        // back-to-back words: one idle cycle between words only
        g_q.delete();
        wr(16'h1234, 1'b1);
        wr(16'h5678, 1'b1);
        drain("d");
        chk("d_frames", 32'(g_q.size()), 32'd4);
        if (g_q.size() == 4) begin
            chk("d_gap_in_word1", 32'(g_q[1]), 32'd0);
            chk("d_gap_between", 32'(g_q[2]), 32'd1);
            chk("d_gap_in_word2", 32'(g_q[3]), 32'd0);
        end

`ifdef PERIPH_TX_PARITY_EN
        p_q.delete();
        wr(16'h0307, 1'b1);
        drain("e");
        chk("e_par_cnt", 32'(p_q.size()), 32'd2);
        if (p_q.size() == 2) begin
            chk("e_par_07", 32'(p_q[0]), 32'd1);
            chk("e_par_03", 32'(p_q[1]), 32'd0);
        end
`endif

        // reset in the middle of data bits, with another word queued
        wr(16'h00FF, 1'b0);
        wr(16'h1234, 1'b0);
        repeat (17) @(negedge clk);
        rx0 = rx_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("f_tx", 32'(tx), 32'd1);
        chk("f_busy", 32'(busy), 32'd0);
        chk("f_full", 32'(full), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("f_tx_quiet", 32'(lows), 32'd0);
        chk("f_no_frames", 32'(rx_cnt - rx0), 32'd0);
        chk("f_busy_end", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
